// File: rtl/sdp_ram_rd_stream_pkg.sv
// Shared definitions for the sdp_ram read streamer: address width, output buffer depth, FSM encodings.
// Latency: none, this file holds definitions only.
// Backpressure: none, this file holds definitions only.
//
// The `FIFO_ADDR_WIDTH, `RD_BUF_DEPTH and state macros are guarded so that an existing
// defines.vh may supply them first.
`ifndef FIFO_ADDR_WIDTH
`define FIFO_ADDR_WIDTH 9
`endif
`ifndef RD_BUF_DEPTH
`define RD_BUF_DEPTH 4
`endif
`ifndef RD_ST_IDLE
`define RD_ST_IDLE  2'd0
`define RD_ST_RUN   2'd1
`define RD_ST_DRAIN 2'd2
`define RD_ST_DONE  2'd3
`endif

package sdp_ram_rd_stream_pkg;

  // Words that may be either in flight in the RAM pipeline or waiting in the output buffer.
  localparam int RD_BUF_DEPTH = `RD_BUF_DEPTH;

  localparam logic [1:0] ST_IDLE  = `RD_ST_IDLE;
  localparam logic [1:0] ST_RUN   = `RD_ST_RUN;
  localparam logic [1:0] ST_DRAIN = `RD_ST_DRAIN;
  localparam logic [1:0] ST_DONE  = `RD_ST_DONE;

endpackage

// File: rtl/rd_stream_buf.sv
// Small synchronous FIFO that holds returned RAM words until the consumer takes them.
// Latency: a push becomes visible at head_data/count on the next cycle.
// Backpressure: none internally; the caller must never push when full.
// Ports: clka/rst clock and sync reset, push/push_data write side, pop read side,
//        head_data oldest entry, count number of stored entries.
module rd_stream_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage is deliberately not reset; only the occupancy state is.
  always_ff @(posedge clka) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clka) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));
  a_no_underflow : assert property (@(posedge clka) disable iff (rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/sdp_ram_rd_stream.sv
// Streams `length` consecutive sdp_ram words from start_addr onto a valid/ready output.
// Latency: first beat L+2 cycles after start (L = RAM read latency), then one word per cycle.
// Backpressure: full; reads are issued only while in-flight plus buffered words stay below 4.
// Ports: clka/rst clock and sync reset; start/start_addr/length command; busy/done status;
//        ram_addrb/ram_enb/ram_regceb/ram_rstb/ram_doutb to sdp_ram port B;
//        m_data/m_valid/m_ready/m_last output stream.
module sdp_ram_rd_stream
  import sdp_ram_rd_stream_pkg::*;
#(
  parameter int    RAM_WIDTH       = 64,
  parameter int    RAM_DEPTH       = 512,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY",
  parameter int    LEN_WIDTH       = 16
) (
  input  logic                        clka,
  input  logic                        rst,
  input  logic                        start,
  input  logic [`FIFO_ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]        length,
  output logic                        busy,
  output logic                        done,
  output logic [`FIFO_ADDR_WIDTH-1:0] ram_addrb,
  output logic                        ram_enb,
  output logic                        ram_regceb,
  output logic                        ram_rstb,
  input  logic [RAM_WIDTH-1:0]        ram_doutb,
  output logic [RAM_WIDTH-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last
);
  localparam int AW = `FIFO_ADDR_WIDTH;
  localparam int L  = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam int CW = $clog2(RD_BUF_DEPTH + 1);

  logic [1:0]           state_q;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued_q;
  logic [LEN_WIDTH-1:0] beats_q;
  logic [L-1:0]         vld_sr;     // one bit per read still inside the RAM pipeline
  logic [CW-1:0]        buf_count;
  logic [CW-1:0]        inflight;
  logic [RAM_WIDTH-1:0] buf_head;
  logic                 credit_ok;
  logic                 issue;
  logic                 last_issue;
  logic                 pop;

  // Every issued-but-unpopped word owns a buffer slot, so the buffer can never overflow.
  assign inflight   = CW'($countones(vld_sr));
  assign credit_ok  = (int'(inflight) + int'(buf_count)) < RD_BUF_DEPTH;
  assign issue      = (state_q == ST_RUN) && (issued_q < len_q) && credit_ok;
  assign last_issue = issue && (issued_q == len_q - LEN_WIDTH'(1));

  assign m_valid = (buf_count != '0);
  assign m_data  = m_valid ? buf_head : '0;   // storage is unreset, so hide it when empty
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beats_q == len_q - LEN_WIDTH'(1));

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign ram_enb    = issue;
  assign ram_addrb  = addr_q;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = rst;

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      beats_q  <= '0;
      vld_sr   <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < L; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end

      if (issue) begin
        issued_q <= issued_q + 1'b1;
        addr_q   <= (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
      end
      if (pop) begin
        beats_q <= beats_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q    <= length;
            addr_q   <= start_addr;
            issued_q <= '0;
            beats_q  <= '0;
            state_q  <= (length != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN:   if (last_issue)     state_q <= ST_DRAIN;
        ST_DRAIN: if (pop && m_last)  state_q <= ST_DONE;
        ST_DONE:                      state_q <= ST_IDLE;
        default:                      state_q <= ST_IDLE;
      endcase
    end
  end

  // The buffer takes the RAM output in the cycle the oldest pipeline bit emerges.
  rd_stream_buf #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (RD_BUF_DEPTH)
  ) u_buf (
    .clka      (clka),
    .rst       (rst),
    .push      (vld_sr[L-1]),
    .push_data (ram_doutb),
    .pop       (pop),
    .head_data (buf_head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_sdp_ram_rd_stream.sv
`ifndef FIFO_ADDR_WIDTH
`define FIFO_ADDR_WIDTH 9
`endif
module tb_sdp_ram_rd_stream;
  localparam int W     = 64;
  localparam int DEPTH = 512;
  localparam int LW    = 16;
  localparam int AW    = `FIFO_ADDR_WIDTH;
  localparam int LOGN  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          m_ready;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;

  // index 0: LOW_LATENCY (L=1), index 1: HIGH_PERFORMANCE (L=2); both get identical stimulus
  logic          busy [2];
  logic          done [2];
  logic          enb [2];
  logic          regceb [2];
  logic          rstb [2];
  logic          m_valid [2];
  logic          m_last [2];
  logic [AW-1:0] addrb [2];
  logic [W-1:0]  doutb [2];
  logic [W-1:0]  m_data [2];

  sdp_ram_rd_stream #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("LOW_LATENCY"), .LEN_WIDTH(LW)) u_dut1 (
    .clka(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy[0]), .done(done[0]), .ram_addrb(addrb[0]), .ram_enb(enb[0]),
    .ram_regceb(regceb[0]), .ram_rstb(rstb[0]), .ram_doutb(doutb[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_last(m_last[0]));

  sdp_ram_rd_stream #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .LEN_WIDTH(LW)) u_dut2 (
    .clka(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy[1]), .done(done[1]), .ram_addrb(addrb[1]), .ram_enb(enb[1]),
    .ram_regceb(regceb[1]), .ram_rstb(rstb[1]), .ram_doutb(doutb[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_last(m_last[1]));

  // Behavioural sdp_ram read ports, preloaded with BRAM[i] = i.
  logic [W-1:0] mem [2][DEPTH];
  logic [W-1:0] rd1 [2];
  logic [W-1:0] rd2 [2];
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mem[k][i] = W'(i);
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (enb[k]) rd1[k] <= mem[k][addrb[k]];
      if (rstb[k]) rd2[k] <= '0;
      else if (regceb[k]) rd2[k] <= rd1[k];
    end
  end
  assign doutb[0] = rd1[0];
  assign doutb[1] = rd2[1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs, written only by the monitor.
  logic [W-1:0] rec_data [2][LOGN];
  int           rec_cyc  [2][LOGN];
  bit           rec_last [2][LOGN];
  int           done_log [2][LOGN];
  int n_rec[2]      = '{0, 0};
  int n_done[2]     = '{0, 0};
  int n_busy[2]     = '{0, 0};
  int n_enb[2]      = '{0, 0};
  int stall_err[2]  = '{0, 0};
  int credit_err[2] = '{0, 0};
  int iss_cnt[2]    = '{0, 0};
  int pop_cnt[2]    = '{0, 0};
  bit hold_prev[2]  = '{0, 0};
  logic [W-1:0] data_prev [2];

  always @(negedge clk) begin
    int outst;
    for (int k = 0; k < 2; k++) begin
      outst = iss_cnt[k] - pop_cnt[k];   // words issued but not yet consumed
      if (hold_prev[k] && (!m_valid[k] || m_data[k] !== data_prev[k])) stall_err[k]++;
      if (outst > 4 || (enb[k] && outst >= 4)) credit_err[k]++;
      if (m_valid[k] && m_ready) begin
        if (n_rec[k] < LOGN) begin
          rec_data[k][n_rec[k]] = m_data[k];
          rec_cyc[k][n_rec[k]]  = cyc;
          rec_last[k][n_rec[k]] = m_last[k];
        end
        n_rec[k]++;
        pop_cnt[k]++;
      end
      if (done[k]) begin
        if (n_done[k] < LOGN) done_log[k][n_done[k]] = cyc;
        n_done[k]++;
      end
      if (busy[k]) n_busy[k]++;
      if (enb[k]) begin
        n_enb[k]++;
        iss_cnt[k]++;
      end
      hold_prev[k] = m_valid[k] && !m_ready;
      data_prev[k] = m_data[k];
      if (rst) begin
        iss_cnt[k]   = 0;
        pop_cnt[k]   = 0;
        hold_prev[k] = 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int snap_rec[2], snap_done[2], snap_busy[2], snap_enb[2], snap_stall[2], snap_cred[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take_snap();
    for (int k = 0; k < 2; k++) begin
      snap_rec[k]   = n_rec[k];
      snap_done[k]  = n_done[k];
      snap_busy[k]  = n_busy[k];
      snap_enb[k]   = n_enb[k];
      snap_stall[k] = stall_err[k];
      snap_cred[k]  = credit_err[k];
    end
  endtask

  task automatic send_start(input int a, input int n, output int c0);
    start_addr = AW'(a);
    length     = LW'(n);
    start      = 1'b1;
    c0         = cyc;
    tick();
    start      = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high in ~30% of cycles
  task automatic wait_done(input int mode, output bit to);
    int guard;
    guard = 0;
    to    = 0;
    while (!(n_done[0] > snap_done[0] && n_done[1] > snap_done[1])) begin
      m_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      tick();
      guard++;
      if (guard > 3000) begin
        to = 1;
        break;
      end
    end
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; start_addr = '0; length = '0;
    tick(); tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (busy[k] !== 1'b0)    begin bad++; $display("FAIL reset_busy dut%0d got=%b want=0", k, busy[k]); end
      total++; if (done[k] !== 1'b0)    begin bad++; $display("FAIL reset_done dut%0d got=%b want=0", k, done[k]); end
      total++; if (m_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got=%b want=0", k, m_valid[k]); end
      total++; if (m_last[k] !== 1'b0)  begin bad++; $display("FAIL reset_last dut%0d got=%b want=0", k, m_last[k]); end
      total++; if (enb[k] !== 1'b0)     begin bad++; $display("FAIL reset_enb dut%0d got=%b want=0", k, enb[k]); end
      total++; if (addrb[k] !== '0)     begin bad++; $display("FAIL reset_addrb dut%0d got=%0h want=0", k, addrb[k]); end
      total++; if (m_data[k] !== '0)    begin bad++; $display("FAIL reset_data dut%0d got=%0h want=0", k, m_data[k]); end
      total++; if (regceb[k] !== 1'b1)  begin bad++; $display("FAIL reset_regceb dut%0d got=%b want=1", k, regceb[k]); end
      total++; if (rstb[k] !== 1'b1)    begin bad++; $display("FAIL reset_rstb dut%0d got=%b want=1", k, rstb[k]); end
    end
    tick();
    rst = 1'b0; m_ready = 1'b1;
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (busy[k] !== 1'b0 || m_valid[k] !== 1'b0 || rstb[k] !== 1'b0) begin
        bad++; $display("FAIL idle_after_reset dut%0d busy=%b valid=%b rstb=%b want 0/0/0", k, busy[k], m_valid[k], rstb[k]);
      end
    end
    tick();
  endtask

  task automatic test_basic();
    int c0; bit to; int a; int n; int idx; int lat;
    a = 10; n = 5;
    take_snap();
    m_ready = 1'b1;
    send_start(a, n, c0);
    wait_done(0, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      total++; if (n_rec[k] - snap_rec[k] != n) begin bad++; $display("FAIL basic_count dut%0d got=%0d want=%0d", k, n_rec[k] - snap_rec[k], n); end
      for (int j = 0; j < n; j++) begin
        idx = snap_rec[k] + j;
        total++; if (rec_data[k][idx] !== W'(a + j)) begin bad++; $display("FAIL basic_data dut%0d beat%0d got=%0d want=%0d", k, j, rec_data[k][idx], a + j); end
        total++; if (rec_cyc[k][idx] != c0 + lat + 2 + j) begin bad++; $display("FAIL basic_cycle dut%0d beat%0d got=%0d want=%0d", k, j, rec_cyc[k][idx] - c0, lat + 2 + j); end
        total++; if (rec_last[k][idx] != (j == n - 1)) begin bad++; $display("FAIL basic_last dut%0d beat%0d got=%0d want=%0d", k, j, rec_last[k][idx], j == n - 1); end
      end
      total++; if (n_done[k] - snap_done[k] != 1) begin bad++; $display("FAIL basic_done_count dut%0d got=%0d want=1", k, n_done[k] - snap_done[k]); end
      total++; if (done_log[k][snap_done[k]] != c0 + n + lat + 2) begin bad++; $display("FAIL basic_done_cycle dut%0d got=%0d want=%0d", k, done_log[k][snap_done[k]] - c0, n + lat + 2); end
      total++; if (n_busy[k] - snap_busy[k] != n + lat + 1) begin bad++; $display("FAIL basic_busy dut%0d got=%0d want=%0d", k, n_busy[k] - snap_busy[k], n + lat + 1); end
      total++; if (n_enb[k] - snap_enb[k] != n) begin bad++; $display("FAIL basic_reads dut%0d got=%0d want=%0d", k, n_enb[k] - snap_enb[k], n); end
      total++; if (credit_err[k] != snap_cred[k]) begin bad++; $display("FAIL basic_credit dut%0d got=%0d want=0", k, credit_err[k] - snap_cred[k]); end
    end
  endtask

  task automatic test_wrap();
    int c0; bit to; int a; int n; int idx;
    a = 510; n = 4;
    take_snap();
    send_start(a, n, c0);
    wait_done(0, to);
    total++; if (to) begin bad++; $display("FAIL wrap_timeout got=timeout want=done"); end
    for (int k = 0; k < 2; k++) begin
      total++; if (n_rec[k] - snap_rec[k] != n) begin bad++; $display("FAIL wrap_count dut%0d got=%0d want=%0d", k, n_rec[k] - snap_rec[k], n); end
      for (int j = 0; j < n; j++) begin
        idx = snap_rec[k] + j;
        total++; if (rec_data[k][idx] !== W'((a + j) % DEPTH)) begin bad++; $display("FAIL wrap_data dut%0d beat%0d got=%0d want=%0d", k, j, rec_data[k][idx], (a + j) % DEPTH); end
        total++; if (rec_last[k][idx] != (j == n - 1)) begin bad++; $display("FAIL wrap_last dut%0d beat%0d got=%0d want=%0d", k, j, rec_last[k][idx], j == n - 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    int c0; bit to; int a; int n; int idx;
    for (int it = 0; it < 3; it++) begin
      a = $urandom_range(0, DEPTH - 1);
      n = (it == 0) ? 20 : $urandom_range(1, 40);
      take_snap();
      send_start(a, n, c0);
      wait_done(1, to);
      total++; if (to) begin bad++; $display("FAIL bp_timeout iter%0d got=timeout want=done", it); end
      for (int k = 0; k < 2; k++) begin
        total++; if (n_rec[k] - snap_rec[k] != n) begin bad++; $display("FAIL bp_count dut%0d iter%0d got=%0d want=%0d", k, it, n_rec[k] - snap_rec[k], n); end
        for (int j = 0; j < n; j++) begin
          idx = snap_rec[k] + j;
          total++; if (rec_data[k][idx] !== W'((a + j) % DEPTH)) begin bad++; $display("FAIL bp_data dut%0d iter%0d beat%0d got=%0d want=%0d", k, it, j, rec_data[k][idx], (a + j) % DEPTH); end
          total++; if (rec_last[k][idx] != (j == n - 1)) begin bad++; $display("FAIL bp_last dut%0d iter%0d beat%0d got=%0d want=%0d", k, it, j, rec_last[k][idx], j == n - 1); end
        end
        total++; if (n_done[k] - snap_done[k] != 1) begin bad++; $display("FAIL bp_done dut%0d iter%0d got=%0d want=1", k, it, n_done[k] - snap_done[k]); end
        total++; if (n_enb[k] - snap_enb[k] != n) begin bad++; $display("FAIL bp_reads dut%0d iter%0d got=%0d want=%0d", k, it, n_enb[k] - snap_enb[k], n); end
        total++; if (stall_err[k] != snap_stall[k]) begin bad++; $display("FAIL bp_stable dut%0d iter%0d got=%0d want=0", k, it, stall_err[k] - snap_stall[k]); end
        total++; if (credit_err[k] != snap_cred[k]) begin bad++; $display("FAIL bp_credit dut%0d iter%0d got=%0d want=0", k, it, credit_err[k] - snap_cred[k]); end
      end
    end
  endtask

  task automatic test_zero_len();
    int c0; bit to;
    take_snap();
    send_start(77, 0, c0);
    wait_done(0, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout got=timeout want=done"); end
    for (int k = 0; k < 2; k++) begin
      total++; if (done_log[k][snap_done[k]] != c0 + 1) begin bad++; $display("FAIL zero_done_cycle dut%0d got=%0d want=1", k, done_log[k][snap_done[k]] - c0); end
      total++; if (n_enb[k] != snap_enb[k]) begin bad++; $display("FAIL zero_reads dut%0d got=%0d want=0", k, n_enb[k] - snap_enb[k]); end
      total++; if (n_rec[k] != snap_rec[k]) begin bad++; $display("FAIL zero_beats dut%0d got=%0d want=0", k, n_rec[k] - snap_rec[k]); end
      total++; if (n_busy[k] != snap_busy[k]) begin bad++; $display("FAIL zero_busy dut%0d got=%0d want=0", k, n_busy[k] - snap_busy[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int c0; int c1; bit to; int a; int n; int idx;
    a = 100; n = 8;
    take_snap();
    send_start(a, n, c0);
    tick(); tick();
    send_start(300, 3, c1);
    wait_done(0, to);
    total++; if (to) begin bad++; $display("FAIL ignore_timeout got=timeout want=done"); end
    for (int k = 0; k < 2; k++) begin
      total++; if (n_rec[k] - snap_rec[k] != n) begin bad++; $display("FAIL ignore_count dut%0d got=%0d want=%0d", k, n_rec[k] - snap_rec[k], n); end
      for (int j = 0; j < n; j++) begin
        idx = snap_rec[k] + j;
        total++; if (rec_data[k][idx] !== W'(a + j)) begin bad++; $display("FAIL ignore_data dut%0d beat%0d got=%0d want=%0d", k, j, rec_data[k][idx], a + j); end
      end
      total++; if (n_done[k] - snap_done[k] != 1) begin bad++; $display("FAIL ignore_done dut%0d got=%0d want=1", k, n_done[k] - snap_done[k]); end
      total++; if (n_enb[k] - snap_enb[k] != n) begin bad++; $display("FAIL ignore_reads dut%0d got=%0d want=%0d", k, n_enb[k] - snap_enb[k], n); end
    end
  endtask

  task automatic test_mid_reset();
    int c0; bit to; int a; int n; int idx;
    m_ready = 1'b1;
    send_start(200, 16, c0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (m_valid[k] !== 1'b0) begin bad++; $display("FAIL midrst_valid dut%0d got=%b want=0", k, m_valid[k]); end
      total++; if (busy[k] !== 1'b0)    begin bad++; $display("FAIL midrst_busy dut%0d got=%b want=0", k, busy[k]); end
      total++; if (enb[k] !== 1'b0)     begin bad++; $display("FAIL midrst_enb dut%0d got=%b want=0", k, enb[k]); end
      total++; if (done[k] !== 1'b0)    begin bad++; $display("FAIL midrst_done dut%0d got=%b want=0", k, done[k]); end
    end
    tick();
    a = 300; n = 3;
    take_snap();
    send_start(a, n, c0);
    wait_done(0, to);
    total++; if (to) begin bad++; $display("FAIL after_rst_timeout got=timeout want=done"); end
    for (int k = 0; k < 2; k++) begin
      total++; if (n_rec[k] - snap_rec[k] != n) begin bad++; $display("FAIL after_rst_count dut%0d got=%0d want=%0d", k, n_rec[k] - snap_rec[k], n); end
      for (int j = 0; j < n; j++) begin
        idx = snap_rec[k] + j;
        total++; if (rec_data[k][idx] !== W'(a + j)) begin bad++; $display("FAIL after_rst_data dut%0d beat%0d got=%0d want=%0d", k, j, rec_data[k][idx], a + j); end
        total++; if (rec_last[k][idx] != (j == n - 1)) begin bad++; $display("FAIL after_rst_last dut%0d beat%0d got=%0d want=%0d", k, j, rec_last[k][idx], j == n - 1); end
      end
      total++; if (done_log[k][snap_done[k]] != c0 + n + k + 3) begin bad++; $display("FAIL after_rst_done dut%0d got=%0d want=%0d", k, done_log[k][snap_done[k]] - c0, n + k + 3); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdp_ram_rd_stream.md
# sdp_ram_rd_stream

Read-side streaming engine for `sdp_ram`. On a start command it reads `length` consecutive words from a start address and presents them on a valid/ready stream with full backpressure. It hides the RAM's 1- or 2-cycle read latency behind a 4-entry credit-managed output buffer. It sits between `sdp_ram` port B and any downstream consumer, and shares `sdp_ram`'s single clock.

## Interface
- `RAM_WIDTH`, 64, data width; must match the attached `sdp_ram`.
- `RAM_DEPTH`, 512, number of RAM entries; addresses wrap modulo this value.
- `RAM_PERFORMANCE`, "LOW_LATENCY", must match `sdp_ram`. Read latency L = 1 for "LOW_LATENCY", otherwise 2.
- `LEN_WIDTH`, 16, width of `length`.

Ports:
- `clka` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe, sampled only in IDLE.
- `start_addr` in `` `FIFO_ADDR_WIDTH ``: first read address (macro from `defines.vh`).
- `length` in `LEN_WIDTH`: number of words to read; 0 is legal.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle completion pulse.
- `ram_addrb` out `` `FIFO_ADDR_WIDTH ``: to `sdp_ram.addrb`.
- `ram_enb` out 1: to `sdp_ram.enb`.
- `ram_regceb` out 1: to `sdp_ram.regceb`; constant 1.
- `ram_rstb` out 1: to `sdp_ram.rstb`; equals `rst`.
- `ram_doutb` in `RAM_WIDTH`: from `sdp_ram.doutb`.
- `m_data` out `RAM_WIDTH`: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final beat of a command.

## Operation
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start` with `length != 0`, go to RUN. On `start` with `length == 0`, go to DONE.
  - RUN: when the read for the final word is issued, go to DRAIN.
  - DRAIN: when the `m_last` beat is handshaken, go to DONE.
  - DONE: one cycle with `done = 1`, then return to IDLE.
- `start` outside IDLE is ignored.
- Read issue:
  - In RUN, `ram_enb = 1` exactly when `issued < length` and `inflight + buf_count < 4`.
  - `ram_enb` and `ram_addrb` are combinational from the state and counters.
  - On each issue, the address increments and wraps from `RAM_DEPTH-1` to 0.
  - `length > RAM_DEPTH` is legal and rereads from the wrapped address.
- Return tracking:
  - An L-deep valid shift register records each issue.
  - When its output is set, `ram_doutb` is written into the output buffer.
  - `inflight` is the popcount of that shift register.
  - The credit rule above guarantees the buffer never overflows. An overflow is a verification failure.
- Output:
  - `m_valid = (buf_count != 0)`. `m_data` is the buffer head.
  - A beat pops when `m_valid && m_ready`.
  - `m_last = m_valid` and the head is the word with index `length-1` (tracked by a beat counter).
- `m_data` is stable while `m_valid && !m_ready`. Words arrive in address order.
- Reset values: `busy` 0, `done` 0, `m_valid` 0, `m_last` 0, `ram_enb` 0, `ram_addrb` 0, `m_data` 0, FSM in IDLE. All counters and pipeline bits are cleared.
- Reset mid-operation:
  - The engine returns to IDLE with the buffer empty.
  - No beat and no `done` pulse appear in the cycle after the reset edge.
  - RAM contents are untouched.
- `start` in the DONE cycle is ignored. `start` is first accepted in the following IDLE cycle.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- Cycle 1: RUN, first `ram_enb`, `ram_addrb = start_addr`.
- Data for a read issued in cycle t enters the buffer at the end of cycle t+L. It is visible on `m_valid` in cycle t+L+1.
- The first beat is therefore in cycle L+2.
- With `m_ready` held high, throughput is 1 word per cycle and there are no bubbles after the first beat.
- For `length = N`, continuous ready:
  - last beat in cycle N+L+1;
  - `done` in cycle N+L+2;
  - `busy` high in cycles 1..N+L+1.
- `length = 0`: `done` in cycle 1, `busy` never asserts, no RAM reads.
- With backpressure, reads stall within at most one cycle of the buffer plus in-flight count reaching 4. No data is lost or duplicated.

## Structure
- Keep `` `FIFO_ADDR_WIDTH `` in `defines.vh`.
- Add the FSM state encodings and the constant `` `RD_BUF_DEPTH `` (4) to `defines.vh`.
- One sub-module, `rd_stream_buf`: a 4-entry synchronous FIFO with push, pop, head data and count outputs. Reset clears the count only.
- The top level holds the FSM, address, issue and beat counters, and the latency shift register.

## Test plan
- RAM preloaded with `BRAM[i] = i`, L = 1, `start_addr = 10`, `length = 5`, `m_ready = 1` → beats 10..14 in cycles 3..7, `m_last` on 14, `done` in cycle 8.
- Same test with L = 2 → first beat in cycle 4, `done` in cycle 9.
- Wrap-around: `start_addr = 510`, `length = 4`, `RAM_DEPTH = 512` → beats 510, 511, 0, 1.
- Backpressure: `length = 20`, `m_ready` driven randomly at 30% → all 20 words in order, `inflight + buf_count` never exceeds 4, `m_data` stable while stalled.
- `length = 0` → `done` in cycle 1, no `ram_enb`, no `m_valid`. A second `start` during RUN → ignored, beat count unchanged.
- `rst` asserted in the middle of a 16-word transfer → next cycle has `m_valid = 0`, `busy = 0`, `ram_enb = 0`. A new 3-word command then completes correctly.
